// File: rtl/crc8_pkg.sv
// crc8_pkg: CRC-8 (poly 0x07) constants and checker state encoding
package crc8_pkg;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/crc8_bit_step.sv
// crc8_bit_step: one MSB-first CRC-8 update for a single data bit
module crc8_bit_step
  import crc8_pkg::*;
(
  input  logic [7:0] crc,
  input  logic       d,
  output logic [7:0] crc_next
);
  always_comb crc_next = {crc[6:0], 1'b0} ^ ((crc[7] ^ d) ? CRC8_POLY : 8'h00);
endmodule

// File: rtl/crc8_checker.sv
// crc8_checker: bit-serial CRC-8 check unit with start/busy/done handshake;
// defining CRC8_CHECK_SYNDROME_EN adds the syndrome port and register
module crc8_checker
  import crc8_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [7:0]        rx_crc,
  output logic              busy,
  output logic              done,
  output logic              match
`ifdef CRC8_CHECK_SYNDROME_EN
  ,
  output logic [7:0]        syndrome
`endif
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [7:0]        r_rx;
  logic [7:0]        r_crc;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        w_crc_next;
  crc8_bit_step u_step (
    .crc      (r_crc),
    .d        (r_shift[DATA_W-1]),
    .crc_next (w_crc_next)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_rx    <= '0;
      r_crc   <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
`ifdef CRC8_CHECK_SYNDROME_EN
      syndrome <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_shift <= data_in;
          r_rx    <= rx_crc;
          r_crc   <= CRC8_INIT;
          r_cnt   <= '0;
          busy    <= 1'b1;
          match   <= 1'b0;
`ifdef CRC8_CHECK_SYNDROME_EN
          syndrome <= '0;
`endif
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_crc   <= w_crc_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            match   <= (w_crc_next == r_rx);
`ifdef CRC8_CHECK_SYNDROME_EN
            syndrome <= w_crc_next ^ r_rx;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc8_checker.sv
// tb_crc8_checker: scoreboard bench for crc8_checker at DATA_W=32 and DATA_W=8
module tb_crc8_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, start8;
  logic [31:0] data_in;
  logic [7:0]  data8;
  logic [7:0]  rx_crc, rx8;
  logic        busy, done, match;
  logic        busy8, done8, match8;
`ifdef CRC8_CHECK_SYNDROME_EN
  logic [7:0]  syndrome, syn8;
`endif
  int          n_checks = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_done8 = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_q8[$];
  logic [8:0]  e, e8;

  always #5 clk = ~clk;

  crc8_checker #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .rx_crc(rx_crc),
    .busy(busy), .done(done), .match(match)
`ifdef CRC8_CHECK_SYNDROME_EN
    , .syndrome(syndrome)
`endif
  );

  crc8_checker #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .data_in(data8), .rx_crc(rx8),
    .busy(busy8), .done(done8), .match(match8)
`ifdef CRC8_CHECK_SYNDROME_EN
    , .syndrome(syn8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [63:0] d, input int w);
    logic [7:0] c = 8'h00;
    for (int i = w - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = exp_q.pop_front();
        check("match", match, e[8]);
`ifdef CRC8_CHECK_SYNDROME_EN
        check("syndrome", syndrome, e[7:0]);
`endif
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (done8) begin
      n_done8++;
      if (exp_q8.size() == 0) check("unexpected_done8", done8, 0);
      else begin
        e8 = exp_q8.pop_front();
        check("match8", match8, e8[8]);
`ifdef CRC8_CHECK_SYNDROME_EN
        check("syndrome8", syn8, e8[7:0]);
`endif
      end
    end
  end

  task automatic wait_done(input int n, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!done && lat < 4 * n) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_check(input logic [31:0] d, input logic [7:0] rx, input logic em, input logic [7:0] es);
    int lat, bc;
    exp_q.push_back({em, es});
    data_in = d;
    rx_crc  = rx;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = $urandom;
    rx_crc  = 8'($urandom);
    check("busy_after_accept", busy, 1);
    wait_done(32, lat, bc);
    check("latency", lat, 32);
    check("busy_cycles", bc, 32);
    check("busy_in_done", busy, 0);
    @(posedge clk); #1;
    check("done_pulse_width", done, 0);
  endtask

  initial begin
    int lat, bc, gap, dn0;
    logic [31:0] rd;
    logic [7:0]  rc, r8;
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    data_in = '0; rx_crc = '0; data8 = '0; rx8 = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
`ifdef CRC8_CHECK_SYNDROME_EN
    check("rst_syndrome", syndrome, 0);
`endif
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // abort mid-SHIFT: reset raised while bit 10 is being processed
    data_in = 32'hDEADBEEF; rx_crc = 8'h5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_match", match, 0);
    check("abort_state", dut.r_state, 0);
    #2 reset = 1'b0;

    do_check(32'h00000001, 8'h07, 1'b1, 8'h00);
    do_check(32'h00000001, 8'h06, 1'b0, 8'h01);
    do_check(32'h00000000, 8'h00, 1'b1, 8'h00);

    // back-to-back with start held high
    dn0 = n_done;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'h00});
    data_in = 32'h00000080; rx_crc = 8'h89; start = 1'b1;
    @(posedge clk); #1;
    data_in = 32'h00000100; rx_crc = 8'h15;
    gap = 0;
    while (busy && gap < 200) begin @(posedge clk); #1; gap++; end
    while (!busy && gap < 200) begin @(posedge clk); #1; gap++; end
    start = 1'b0;
    check("b2b_accept_gap", gap, 34);
    wait_done(32, lat, bc);
    check("b2b_latency", lat, 32);
    @(posedge clk); #1;
    check("b2b_done_count", n_done - dn0, 2);

    // start pulses in SHIFT and DONE are ignored
    dn0 = n_done;
    exp_q.push_back({1'b1, 8'h00});
    data_in = 32'h00000001; rx_crc = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 data_in = 32'hFFFF0000; rx_crc = 8'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(32, lat, bc);
    check("lat_with_shift_pulse", lat, 26);
    data_in = 32'h12345678; rx_crc = 8'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("no_restart_from_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("stays_idle", busy, 0);
    check("single_done", n_done - dn0, 1);

    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      rc = (i % 2 == 0) ? crc_ref({32'h0, rd}, 32) : 8'($urandom);
      do_check(rd, rc, crc_ref({32'h0, rd}, 32) == rc, crc_ref({32'h0, rd}, 32) ^ rc);
    end

    // DATA_W=8 instance
    for (int i = 0; i < 3; i++) begin
      data8 = (i == 0) ? 8'h80 : 8'($urandom);
      r8    = (i == 0) ? 8'h89 : ((i == 1) ? crc_ref({56'h0, data8}, 8) : 8'($urandom));
      rx8   = r8;
      exp_q8.push_back({crc_ref({56'h0, data8}, 8) == r8, crc_ref({56'h0, data8}, 8) ^ r8});
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
      check("lat8", lat, 8);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("queue8_empty", exp_q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
